uart_tx_mmio: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_mmio_if.sv | 11 +
 rtl/uart_fifo.sv | 47 ++++
 rtl/uart_tx_mmio.sv | 154 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  localparam int BUSY    = 0;
  localparam int FULL    = 1;
  localparam int EMPTY   = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 8;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [4:0] cnt);
    logic [31:0] s;
    s              = '0;
    s[BUSY]        = busy;
    s[FULL]        = full;
    s[EMPTY]       = empty;
    s[OVF]         = ovf;
    s[CNT_LSB +: 5] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Datapath store/load bus as seen by the UART: write enable, address, data, read-back and decode hit.
interface uart_tx_mmio_if;
  logic [1:0]  WE;
  logic [31:0] ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Hit;

  modport master (output WE, output ADDR, output WD, input RD, input Hit);
  modport slave  (input WE, input ADDR, input WD, output RD, output Hit);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head; pushes when full are ignored unless a pop frees the slot.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO 8N1 UART transmitter: TXDATA stores queue bytes, STATUS reads combinationally.
// First start bit appears two edges after a store into an idle FIFO; stores to a full FIFO are dropped and flagged.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          CLK_DIV    = 10417,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           TX,
  output logic           TxIdle
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  uart_state_t state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          ovf;

  logic          wr, sel_status, push_req, push, pop;
  logic          full, empty;
  logic [7:0]    head;
  logic [AW:0]   count;
  logic          tick;
  logic          unused_bits;

  assign unused_bits = ^{bus.WD[31:8], bus.ADDR[1:0]};

  assign bus.Hit    = (bus.ADDR[31:3] == BASE_ADDR[31:3]);
  assign wr         = (bus.WE != 2'b00) && bus.Hit;
  assign sel_status = (bus.ADDR[2] == STATUS_OFF[2]);
  assign push_req   = wr && !sel_status;
  // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
  assign push       = push_req && (!full || pop);

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.WD[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr && sel_status) begin
      ovf <= 1'b0;
    end else if (push_req && !push) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    bus.RD = '0;
    if (bus.Hit && sel_status) begin
      bus.RD = pack_status(state != IDLE, full, empty, ovf, 5'(count));
    end
  end

  assign TxIdle = empty && (state == IDLE);
  assign tick   = (baud_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      TX       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    pop        = 1'b0;
    tx_n       = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_n    = head;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (tick) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          baud_cnt_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // The line register follows the state being entered, so TX changes exactly on bit boundaries.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomized checks of uart_tx_mmio against a frame-level line model.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic TX;
  logic TxIdle;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .TX     (TX),
    .TxIdle (TxIdle)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  typedef struct packed {
    logic [7:0]  data;
    logic        start_b;
    logic        stop_b;
    logic [31:0] t0;
  } frame_t;

  frame_t      rxq[$];
  logic [7:0]  expq[$];
  bit          expc[$];
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes frames by sampling the middle of each bit period.
  bit     in_frame = 0;
  int     fcnt = 0;
  frame_t cur;
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (TX === 1'b0) begin
        in_frame = 1;
        fcnt     = 0;
        cur      = '0;
        cur.t0   = cyc;
      end
    end else begin
      fcnt++;
      if (fcnt == DIV / 2) cur.start_b = TX;
      if (fcnt >= DIV + DIV / 2 && fcnt < 9 * DIV && ((fcnt - DIV / 2) % DIV) == 0)
        cur.data[(fcnt - DIV / 2) / DIV - 1] = TX;
      if (fcnt == 9 * DIV + DIV / 2) cur.stop_b = TX;
      if (fcnt == FRAME - 1) begin
        rxq.push_back(cur);
        in_frame = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [31:0] a, input logic [7:0] d);
    bus.WE   = 2'($urandom_range(1, 3));
    bus.ADDR = a;
    bus.WD   = {24'($urandom), d};
    @(negedge clk);
    bus.WE   = 2'b00;
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d);
    bus.WE   = 2'b00;
    bus.ADDR = a;
    #1;
    d = bus.RD;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(TxIdle === 1'b1 && !in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'b0, (n < budget)}, 32'd1);
  endtask

  // Expected line level for bit slot k of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return logic'((b >> (k - 1)) & 8'd1);
  endfunction

  task automatic compare_frames();
    frame_t      f;
    logic [7:0]  e;
    bit          c;
    logic [31:0] prev_t0;
    prev_t0 = '0;
    check("frame_count", 32'(rxq.size()), 32'(expq.size()));
    while (expq.size() > 0 && rxq.size() > 0) begin
      f = rxq.pop_front();
      e = expq.pop_front();
      c = expc.pop_front();
      check("frame_start_bit", {31'b0, f.start_b}, 32'd0);
      check("frame_stop_bit", {31'b0, f.stop_b}, 32'd1);
      check("frame_data", {24'b0, f.data}, {24'b0, e});
      if (c) check("frame_gap", f.t0 - prev_t0, 32'(FRAME));
      prev_t0 = f.t0;
    end
    expq.delete();
    expc.delete();
    rxq.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          k;
    int          cnt;

    bus.WE = 2'b00; bus.ADDR = '0; bus.WD = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    check("idle_tx", {31'b0, TX}, 32'd1);
    check("idle_txidle", {31'b0, TxIdle}, 32'd1);
    read(BASE + 32'd4, rd);
    check("reset_status", rd, 32'h0000_0004);
    check("status_hit", {31'b0, bus.Hit}, 32'd1);

    // Single frame 0xA5, line sampled mid-bit
    write(BASE, 8'hA5);
    check("tx_high_after_push", {31'b0, TX}, 32'd1);
    @(negedge clk);
    check("tx_fall_latency", {31'b0, TX}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? DIV / 2 : DIV) @(negedge clk);
      check("a5_line_bit", {31'b0, TX}, {31'b0, frame_bit(8'hA5, i)});
    end
    repeat (FRAME - 1 - (9 * DIV + DIV / 2)) @(negedge clk);
    check("txidle_last_stop_cycle", {31'b0, TxIdle}, 32'd0);
    @(negedge clk);
    check("txidle_after_frame", {31'b0, TxIdle}, 32'd1);
    expq.push_back(8'hA5); expc.push_back(1'b0);
    compare_frames();

    // Three back-to-back stores -> contiguous frames
    expq = '{8'h11, 8'h22, 8'h33}; expc = '{1'b0, 1'b1, 1'b1};
    write(BASE, 8'h11); write(BASE, 8'h22); write(BASE, 8'h33);
    read(BASE + 32'd4, rd);
    check("status_count_two", rd, 32'h0000_0201);
    wait_idle(400);
    compare_frames();

    // Six consecutive stores into a 4-deep FIFO -> overflow on the sixth
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        expq.push_back(8'h60 + 8'(i));
        expc.push_back(i > 0);
      end
      write(BASE, 8'h60 + 8'(i));
    end
    read(BASE + 32'd4, rd);
    check("status_full_ovf", rd, 32'h0000_040B);
    write(BASE + 32'd4, 8'($urandom));
    read(BASE + 32'd4, rd);
    check("status_ovf_cleared", rd, 32'h0000_0403);
    wait_idle(600);
    compare_frames();

    // Reset during the start bit: line must return high without a clock edge
    write(BASE, 8'h5A);
    @(negedge clk);
    check("start_bit_low", {31'b0, TX}, 32'd0);
    repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_tx_start", {31'b0, TX}, 32'd1);
    check("async_reset_txidle", {31'b0, TxIdle}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rxq.delete();

    // Reset during data bit 3 of 0x5A, then a clean frame
    repeat (3) @(negedge clk);
    write(BASE, 8'h5A);
    @(negedge clk);
    repeat (4 * DIV + 1) @(negedge clk);
    check("bit3_level", {31'b0, TX}, {31'b0, frame_bit(8'h5A, 4)});
    reset = 1'b1;
    #1;
    check("async_reset_tx_data", {31'b0, TX}, 32'd1);
    read(BASE + 32'd4, rd);
    check("reset_fifo_empty", rd, 32'h0000_0004);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rxq.delete();
    repeat (3) @(negedge clk);
    expq.push_back(8'h5A); expc.push_back(1'b0);
    write(BASE, 8'h5A);
    wait_idle(200);
    compare_frames();

    // Out-of-window stores and loads
    bus.WE = 2'b01; bus.ADDR = BASE + 32'd8; bus.WD = 32'h0000_0077;
    #1;
    check("miss_hi_hit", {31'b0, bus.Hit}, 32'd0);
    check("miss_hi_rd", bus.RD, 32'd0);
    @(negedge clk);
    bus.WE = 2'b10; bus.ADDR = BASE - 32'd4; bus.WD = 32'h0000_0088;
    #1;
    check("miss_lo_hit", {31'b0, bus.Hit}, 32'd0);
    check("miss_lo_rd", bus.RD, 32'd0);
    @(negedge clk);
    bus.WE = 2'b00;
    read(BASE + 32'd4, rd);
    check("miss_no_fifo_change", rd, 32'h0000_0004);
    repeat (DIV * 3) @(negedge clk);
    check("miss_no_frame", 32'(rxq.size()), 32'd0);
    read(BASE, rd);
    check("txdata_reads_zero", rd, 32'd0);

    // Randomized bursts from idle, each within FIFO capacity plus the first pop
    for (int it = 0; it < 15; it++) begin
      k = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        expq.push_back(b);
        expc.push_back(i > 0);
        write(BASE, b);
      end
      cnt = (k == 1) ? 1 : k - 1;
      read(BASE + 32'd4, rd);
      check("burst_status", rd, (32'(cnt) << 8) | ((cnt == DEPTH) ? 32'd2 : 32'd0)
                                 | ((k >= 2) ? 32'd1 : 32'd0));
      wait_idle((k + 1) * FRAME + 20);
      compare_frames();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
